// File: rtl/direction_frame_scheduler.sv
// Per-bin scheduler for the shared direction calculator: one bin per cycle to the calculator,
// qualified x/y accumulated over a frame, frame total handed off on valid/ready.
module direction_frame_scheduler #(
  parameter int BIN_WIDTH = 10,
  parameter int ACC_WIDTH = 26
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       bin_valid_in,
  output logic                       bin_ready_out,
  input  logic [BIN_WIDTH-1:0]       bin_index_in,
  input  logic                       bin_last_in,
  input  logic [31:0]                central_mic_in,
  input  logic [2:0][31:0]           peripheral_mics_in,
  input  logic [BIN_WIDTH-1:0]       bin_lo_in,
  input  logic [BIN_WIDTH-1:0]       bin_hi_in,
  input  logic [15:0]                mag_thresh_in,
  output logic [31:0]                calc_central_out,
  output logic [2:0][31:0]           calc_peripheral_out,
  input  logic [31:0]                calc_vector_in,
  output logic [ACC_WIDTH-1:0]       dir_x_out,
  output logic [ACC_WIDTH-1:0]       dir_y_out,
  output logic [BIN_WIDTH:0]         bin_count_out,
  output logic                       out_valid_out,
  input  logic                       out_ready_in
);

  typedef enum logic {ACCUM, DONE} state_t;

  state_t               state;
  logic                 stage_valid, stage_last, stage_use;
  logic [ACC_WIDTH-1:0] acc_x, acc_y;
  logic [BIN_WIDTH:0]   count;

  logic                 accept, qualify;
  logic [ACC_WIDTH-1:0] vec_x, vec_y, next_x, next_y;
  logic [BIN_WIDTH:0]   next_count;

  // Stall the beat right after a frame's last one so the next frame cannot mix in.
  assign bin_ready_out = (state == ACCUM) && !(stage_valid && stage_last);
  assign accept        = bin_valid_in && bin_ready_out;
  assign qualify       = (bin_index_in >= bin_lo_in) && (bin_index_in <= bin_hi_in) &&
                         (central_mic_in[15:0] >= mag_thresh_in);

  assign vec_x      = {{(ACC_WIDTH-16){calc_vector_in[15]}}, calc_vector_in[15:0]};
  assign vec_y      = {{(ACC_WIDTH-16){calc_vector_in[31]}}, calc_vector_in[31:16]};
  assign next_x     = stage_use ? acc_x + vec_x : acc_x;
  assign next_y     = stage_use ? acc_y + vec_y : acc_y;
  assign next_count = stage_use ? count + 1'b1 : count;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state               <= ACCUM;
      stage_valid         <= 1'b0;
      stage_last          <= 1'b0;
      stage_use           <= 1'b0;
      acc_x               <= '0;
      acc_y               <= '0;
      count               <= '0;
      calc_central_out    <= '0;
      calc_peripheral_out <= '0;
      dir_x_out           <= '0;
      dir_y_out           <= '0;
      bin_count_out       <= '0;
      out_valid_out       <= 1'b0;
    end else begin
      stage_valid <= accept;
      if (accept) begin
        calc_central_out    <= central_mic_in;
        calc_peripheral_out <= peripheral_mics_in;
        stage_last          <= bin_last_in;
        stage_use           <= qualify;
      end

      // Calculator result for the beat accepted last cycle arrives now.
      if (stage_valid) begin
        if (stage_last) begin
          dir_x_out     <= next_x;
          dir_y_out     <= next_y;
          bin_count_out <= next_count;
          acc_x         <= '0;
          acc_y         <= '0;
          count         <= '0;
          state         <= DONE;
          out_valid_out <= 1'b1;
        end else begin
          acc_x <= next_x;
          acc_y <= next_y;
          count <= next_count;
        end
      end

      if (state == DONE && out_ready_in) begin
        out_valid_out <= 1'b0;
        state         <= ACCUM;
      end
    end
  end

endmodule

// File: doc/direction_frame_scheduler.md
Name: direction_frame_scheduler

Overview:
- Sequences per-bin FFT/CORDIC results from the four microphones through the shared combinational direction calculator, one bin per cycle.
- Qualifies each bin by index range and central magnitude, accumulates the qualifying x/y direction vectors over one frame, and hands the frame total plus contributing-bin count downstream on a valid/ready handshake.
- Sits between the per-mic polar-conversion stage and the angle/visualisation stage.

Parameters:
- BIN_WIDTH, 10, width of the bin index (1024-point FFT).
- ACC_WIDTH, 26, width of the signed x/y accumulators; must be at least 16+BIN_WIDTH.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- bin_valid_in  input  1  a bin beat is presented.
- bin_ready_out  output  1  scheduler accepts the beat this cycle.
- bin_index_in  input  BIN_WIDTH  FFT bin index of the beat.
- bin_last_in  input  1  final beat of the frame.
- central_mic_in  input  32  {phase[31:16], mag[15:0]}, 3.13 format.
- peripheral_mics_in  input  32 x3  same format, mics 1..3.
- bin_lo_in  input  BIN_WIDTH  lowest qualifying bin, inclusive.
- bin_hi_in  input  BIN_WIDTH  highest qualifying bin, inclusive.
- mag_thresh_in  input  16  minimum central magnitude, unsigned compare.
- calc_central_out  output  32  registered drive to the calculator's central input.
- calc_peripheral_out  output  32 x3  registered drive to the calculator's peripheral inputs.
- calc_vector_in  input  32  calculator result {y[31:16], x[15:0]}, signed 7.9.
- dir_x_out  output  ACC_WIDTH  signed frame sum of x.
- dir_y_out  output  ACC_WIDTH  signed frame sum of y.
- bin_count_out  output  BIN_WIDTH+1  number of qualifying bins in the frame.
- out_valid_out  output  1  frame result valid.
- out_ready_in  input  1  downstream accepts the result.

Behaviour:
- States:
  - ACCUM: collecting beats.
  - DONE: presenting the frame result.
- Reset (rst_in sampled high at a clock edge):
  - State goes to ACCUM.
  - Accumulators, count, stage registers, calc_*_out, dir_*_out and bin_count_out all go to 0.
  - out_valid_out goes to 0.
  - Reset mid-frame discards the partial frame; no result is emitted for it.
- bin_ready_out = (state==ACCUM) && !(stage_valid && stage_last). This is combinational from state and stage registers only, never from bin_valid_in.
- Accept at edge T (bin_valid_in && bin_ready_out):
  - Register the mic words into calc_*_out.
  - Set stage_valid=1 and stage_last=bin_last_in.
  - Set stage_use = (bin_lo_in <= bin_index_in <= bin_hi_in) && (mag >= mag_thresh_in), with mag taken from central_mic_in[15:0] and all compares unsigned.
  - If no beat is accepted, stage_valid is 0 the next cycle.
- Edge T+1, when stage_valid && stage_use:
  - acc_x += sign-extended calc_vector_in[15:0].
  - acc_y += sign-extended calc_vector_in[31:16].
  - count += 1.
  - Throughput is one beat per cycle; latency is one cycle from acceptance to accumulation.
- Edge T+1, when stage_valid && stage_last:
  - dir_x_out, dir_y_out and bin_count_out take the final totals, including this beat's contribution.
  - Accumulators and count clear to 0.
  - State goes to DONE and out_valid_out goes to 1.
  - The cycle after the last beat has bin_ready_out=0, so the next frame cannot mix in.
- DONE:
  - bin_ready_out=0.
  - Outputs are held stable while out_valid_out && !out_ready_in.
  - At the edge where out_ready_in=1, out_valid_out drops to 0 and state returns to ACCUM. The next beat can be accepted in the following cycle.
- Frame with zero qualifying bins: emits sums 0 and count 0; this is not an error.
- Single-beat frame (first beat also last): handled identically to a longer frame.
- bin_lo_in > bin_hi_in: no bin qualifies.
- Config ports are sampled at acceptance and may change between beats.
- No overflow is possible: ACC_WIDTH >= 16+BIN_WIDTH, and count is 1 bit wider than the index.
- calc_*_out holds its last value when no beat is accepted.

Test Plan:
- Reset then idle: rst_in high for 2 cycles, then bin_valid_in=0 for 10 cycles -> bin_ready_out=1, out_valid_out=0, all outputs 0.
- 4-beat frame, bins 5..8, lo=0, hi=1023, thresh=0, model calculator returns x=0x0100, y=0xFF00 each beat, back-to-back beats with last on bin 8 -> one cycle after last: out_valid_out=1, dir_x_out=0x400, dir_y_out=-0x400, bin_count_out=4; bin_ready_out=0 in that cycle and throughout DONE.
- Qualification: 6 beats on bins 2..7 with lo=3, hi=5, thresh=0x0200, beat mags 0x0300 except bin 4 at 0x01FF, x=1 each -> dir_x_out=2, bin_count_out=2.
- Backpressure: hold out_ready_in=0 for 7 cycles after out_valid_out rises -> outputs stable, bin_valid_in ignored; raise out_ready_in for one cycle -> out_valid_out=0 next cycle; the next frame's first beat is then accepted and accumulators start from 0.
- Sign and empty frame: a frame alternating x=0x7FFF and x=0x8000 over 2 beats -> dir_x_out=-1; a frame with lo=10, hi=3 -> count 0, sums 0, out_valid_out still asserted.
- Reset mid-frame: assert rst_in after 3 of 5 beats, then send a fresh 2-beat frame -> the first result reflects only the 2 new beats.
